instr_prefetch: RTL and testbench

//  Byte-wide instruction prefetch queue between the 8-bit memory bus and the core's

---
 rtl/core_pkg.sv | 11 +
 rtl/instr_prefetch_if.sv | 34 +++
 rtl/prefetch_ram.sv | 24 ++
 rtl/instr_prefetch.sv | 127 ++++++++++++
 tb/tb_instr_prefetch.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the instruction prefetch queue.
//   DEPTH_DEF  default queue depth in bytes (power of 2, >= 2)
//   pf_state_e bus-side fetch FSM: S_IDLE (no read outstanding), S_REQ (read on bus)
package core_pkg;
  localparam int DEPTH_DEF = 8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } pf_state_e;
endpackage

// File: rtl/instr_prefetch_if.sv
// Bundle of every prefetch-queue signal except clock/reset.
//   core side  : locked, flush, flush_addr, q_take -> q_valid, q_byte, q_addr, q_count
//   memory bus : mem_req, mem_address -> mem_in, mem_ready
//   snoop      : snoop_we, snoop_addr (core data writes)
// master = the prefetch unit, slave = core + memory + snoop sources.
interface instr_prefetch_if import core_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF,
  parameter int PW    = $clog2(DEPTH)
) ();
  logic          locked;
  logic          flush;
  logic [31:0]   flush_addr;
  logic          q_take;
  logic          q_valid;
  logic [7:0]    q_byte;
  logic [31:0]   q_addr;
  logic [PW:0]   q_count;
  logic          mem_req;
  logic [31:0]   mem_address;
  logic [7:0]    mem_in;
  logic          mem_ready;
  logic          snoop_we;
  logic [31:0]   snoop_addr;

  modport master (
    input  locked, flush, flush_addr, q_take, mem_in, mem_ready, snoop_we, snoop_addr,
    output q_valid, q_byte, q_addr, q_count, mem_req, mem_address
  );

  modport slave (
    output locked, flush, flush_addr, q_take, mem_in, mem_ready, snoop_we, snoop_addr,
    input  q_valid, q_byte, q_addr, q_count, mem_req, mem_address
  );
endinterface

// File: rtl/prefetch_ram.sv
// DEPTH x 8 queue storage: one synchronous write port, one asynchronous read
// port, no reset, so it can map onto distributed/LUT RAM.
//   clock    write clock
//   we_i     write enable
//   waddr_i  write pointer, wdata_i write byte
//   raddr_i  read pointer,  rdata_o byte at raddr_i (combinational)
module prefetch_ram #(
  parameter int DEPTH = 8,
  parameter int PW    = 3
) (
  input  logic          clock,
  input  logic          we_i,
  input  logic [PW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [PW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);
  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clock)
    if (we_i) mem_q[waddr_i] <= wdata_i;

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/instr_prefetch.sv
// Byte-wide instruction prefetch queue. Runs ahead of the core on the 8-bit
// memory bus (one read outstanding at most), holds up to DEPTH bytes and
// presents the head byte with its linear address.
//   clock, reset  system clock; asynchronous active-high reset
//   bus           instr_prefetch_if.master (core, memory and snoop signals)
// A flush, or a core write landing on a queued/in-flight byte, empties the
// queue; a read already on the bus completes with its data discarded (drop).
module instr_prefetch import core_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  instr_prefetch_if.master  bus
);
  localparam int CW = PW + 1;

  pf_state_e     state_q, state_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   q_addr_q, q_addr_d, fetch_addr_q, fetch_addr_d, mem_addr_q, mem_addr_d;
  logic          drop_q, drop_d, started_q, started_d;
  logic          take, fill, pend, snoop_hit, ram_we;
  logic [31:0]   snoop_off, inv_addr;
  logic [7:0]    ram_rdata;

  assign take = bus.q_take && (count_q != '0);
  // A non-dropped read in flight already owns a slot and a stream address.
  assign pend = (state_q == S_REQ) && !drop_q;
  assign fill = (state_q == S_REQ) && bus.mem_ready && !drop_q;
  // Wrap-safe window test: offset from the head, modulo 2^32.
  assign snoop_off = bus.snoop_addr - q_addr_q;
  assign snoop_hit = bus.snoop_we && (snoop_off < (32'(count_q) + 32'(pend)));
  assign inv_addr  = bus.flush ? bus.flush_addr : q_addr_q + 32'(take);

  always_comb begin
    state_d      = state_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    q_addr_d     = q_addr_q;
    fetch_addr_d = fetch_addr_q;
    mem_addr_d   = mem_addr_q;
    drop_d       = drop_q;
    started_d    = started_q;
    ram_we       = 1'b0;
    if (bus.flush || snoop_hit) begin
      count_d      = '0;
      rd_ptr_d     = wr_ptr_q;
      q_addr_d     = inv_addr;
      fetch_addr_d = inv_addr;
      started_d    = started_q | bus.flush;
      // mem_req must stay up until the bus read finishes; its data is dropped.
      if ((state_q == S_REQ) && !bus.mem_ready) begin
        drop_d = 1'b1;
      end else begin
        drop_d  = 1'b0;
        state_d = S_IDLE;
      end
    end else begin
      if (take) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        q_addr_d = q_addr_q + 32'd1;
      end
      if (fill) begin
        ram_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(fill) - CW'(take);
      case (state_q)
        S_IDLE:
          if (started_q && (count_q < CW'(DEPTH))) begin
            state_d    = S_REQ;
            mem_addr_d = fetch_addr_q;
          end
        S_REQ:
          if (bus.mem_ready) begin
            state_d = S_IDLE;
            drop_d  = 1'b0;
            // After a drop fetch_addr already points at the new stream.
            if (!drop_q) fetch_addr_d = fetch_addr_q + 32'd1;
          end
      endcase
    end
  end

  // locked=0 freezes every register, including the RAM write.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q      <= S_IDLE;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      q_addr_q     <= '0;
      fetch_addr_q <= '0;
      mem_addr_q   <= '0;
      drop_q       <= 1'b0;
      started_q    <= 1'b0;
    end else if (bus.locked) begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      q_addr_q     <= q_addr_d;
      fetch_addr_q <= fetch_addr_d;
      mem_addr_q   <= mem_addr_d;
      drop_q       <= drop_d;
      started_q    <= started_d;
    end

  prefetch_ram #(.DEPTH(DEPTH), .PW(PW)) u_ram (
    .clock   (clock),
    .we_i    (ram_we && bus.locked && !reset),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.mem_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  assign bus.q_valid     = (count_q != '0);
  // Masked so q_byte reads 0 out of reset and whenever the queue is empty.
  assign bus.q_byte      = bus.q_valid ? ram_rdata : 8'h00;
  assign bus.q_addr      = q_addr_q;
  assign bus.q_count     = count_q;
  assign bus.mem_req     = (state_q == S_REQ);
  assign bus.mem_address = mem_addr_q;
endmodule

// File: tb/tb_instr_prefetch.sv
module tb_instr_prefetch;
  localparam int DEPTH = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  instr_prefetch_if #(.DEPTH(DEPTH)) bus ();

  instr_prefetch #(.DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Memory image: byte at address a. 0x000F8000.. reads 0x11,0x22,..
  function automatic logic [7:0] memf(input logic [31:0] a);
    logic [7:0] l;
    l = a[7:0] + 8'd1;
    return 8'(l * 8'd17);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: one-cycle ready after it sees a request.
  bit resp_en = 1'b1;
  bit force_ready = 1'b0;
  always @(posedge clock) begin
    #1;
    bus.mem_ready = force_ready || (resp_en && bus.mem_req && !bus.mem_ready);
    bus.mem_in    = memf(bus.mem_address);
  end

  // Behavioural model: queue length, head address, and whether the bus read
  // in flight belongs to a discarded stream.
  int          m_count = 0;
  logic [31:0] m_qaddr = '0;
  bit          m_drop  = 1'b0;
  always @(posedge clock) begin
    bit tk, hit, fl;
    int pend;
    if (reset) begin
      m_count = 0; m_qaddr = '0; m_drop = 1'b0;
    end else if (bus.locked) begin
      tk   = bus.q_take && (m_count != 0);
      pend = (bus.mem_req && !m_drop) ? 1 : 0;
      hit  = bus.snoop_we && ((bus.snoop_addr - m_qaddr) < 32'(m_count + pend));
      if (bus.flush || hit) begin
        m_qaddr = bus.flush ? bus.flush_addr : m_qaddr + (tk ? 32'd1 : 32'd0);
        m_count = 0;
        m_drop  = bus.mem_req && !bus.mem_ready;
      end else begin
        fl = bus.mem_req && bus.mem_ready && !m_drop;
        if (bus.mem_req && bus.mem_ready) m_drop = 1'b0;
        m_count = m_count + (fl ? 1 : 0) - (tk ? 1 : 0);
        if (tk) m_qaddr = m_qaddr + 32'd1;
      end
    end
  end

  // Per-cycle compare against the model.
  bit          prev_req  = 1'b0;
  logic [31:0] prev_addr = '0;
  always @(posedge clock) begin
    #3;
    chk("q_count", 32'(bus.q_count), 32'(m_count));
    chk("q_valid", 32'(bus.q_valid), (m_count != 0) ? 32'd1 : 32'd0);
    chk("q_addr", bus.q_addr, m_qaddr);
    chk("q_byte", 32'(bus.q_byte), (m_count != 0) ? 32'(memf(m_qaddr)) : 32'd0);
    if (bus.mem_req && !m_drop)
      chk("mem_address_stream", bus.mem_address, m_qaddr + 32'(m_count));
    if (prev_req && bus.mem_req)
      chk("mem_address_stable", bus.mem_address, prev_addr);
    prev_req  = bus.mem_req && !reset;
    prev_addr = bus.mem_address;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  task automatic wait_count(input int n);
    for (int i = 0; i < 60 && int'(bus.q_count) != n; i++) @(negedge clock);
    chk("wait_count_timeout", 32'(bus.q_count), 32'(n));
  endtask

  task automatic wait_req(input logic v);
    for (int i = 0; i < 60 && bus.mem_req != v; i++) @(negedge clock);
    chk("wait_req_timeout", 32'(bus.mem_req), 32'(v));
  endtask

  task automatic pulse_flush(input logic [31:0] a);
    bus.flush = 1'b1; bus.flush_addr = a;
    tick(1);
    bus.flush = 1'b0;
  endtask

  task automatic pulse_snoop(input logic [31:0] a, input logic tk);
    bus.snoop_we = 1'b1; bus.snoop_addr = a; bus.q_take = tk;
    tick(1);
    bus.snoop_we = 1'b0; bus.q_take = 1'b0;
  endtask

  logic [7:0] seq [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

  initial begin
    int hold;
    bus.locked = 1'b1; bus.flush = 1'b0; bus.flush_addr = '0; bus.q_take = 1'b0;
    bus.snoop_we = 1'b0; bus.snoop_addr = '0; bus.mem_in = '0; bus.mem_ready = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);
    // Reset state; nothing is fetched before the first flush.
    chk("rst_q_valid", 32'(bus.q_valid), 32'd0);
    chk("rst_q_byte", 32'(bus.q_byte), 32'd0);
    chk("rst_q_addr", bus.q_addr, 32'd0);
    chk("rst_q_count", 32'(bus.q_count), 32'd0);
    chk("rst_mem_address", bus.mem_address, 32'd0);
    tick(4);
    chk("no_fetch_before_flush", 32'(bus.mem_req), 32'd0);

    // 1: fill to full.
    pulse_flush(32'h000F_8000);
    wait_count(8);
    tick(2);
    chk("t1_count", 32'(bus.q_count), 32'd8);
    chk("t1_mem_req", 32'(bus.mem_req), 32'd0);
    chk("t1_q_byte", 32'(bus.q_byte), 32'h11);
    chk("t1_q_addr", bus.q_addr, 32'h000F_8000);

    // 2: drain in order while refilling.
    for (int i = 0; i < 8; i++) begin
      chk("t2_byte", 32'(bus.q_byte), 32'(seq[i]));
      bus.q_take = 1'b1;
      tick(1);
    end
    bus.q_take = 1'b0;
    chk("t2_q_addr", bus.q_addr, 32'h000F_8008);

    // 3: flush while 0x000F8005 is on the bus.
    pulse_flush(32'h000F_8000);
    wait_count(5);
    resp_en = 1'b0;
    tick(1);
    chk("t3_req", 32'(bus.mem_req), 32'd1);
    chk("t3_inflight_addr", bus.mem_address, 32'h000F_8005);
    resp_en = 1'b1;
    pulse_flush(32'h0000_1234);
    wait_req(1'b0);
    wait_req(1'b1);
    chk("t3_new_addr", bus.mem_address, 32'h0000_1234);
    wait_count(1);
    chk("t3_first_byte", 32'(bus.q_byte), 32'h85);
    chk("t3_first_addr", bus.q_addr, 32'h0000_1234);

    // 4: snoop hit inside the window, then a miss, then a hit with take.
    wait_count(6);
    resp_en = 1'b0;
    tick(1);
    pulse_snoop(32'h0000_1236, 1'b0);
    chk("t4_hit_count", 32'(bus.q_count), 32'd0);
    chk("t4_hit_addr", bus.q_addr, 32'h0000_1234);
    resp_en = 1'b1;
    wait_req(1'b0);
    wait_req(1'b1);
    chk("t4_refetch_addr", bus.mem_address, 32'h0000_1234);
    wait_count(8);
    wait_req(1'b0);
    pulse_snoop(32'h0000_1240, 1'b0);
    chk("t4_miss_count", 32'(bus.q_count), 32'd8);
    pulse_snoop(32'h0000_1234, 1'b1);
    chk("t4_take_hit_count", 32'(bus.q_count), 32'd0);
    chk("t4_take_hit_addr", bus.q_addr, 32'h0000_1235);

    // 5: stream crossing 0xFFFFFFFF.
    pulse_flush(32'hFFFF_FFFE);
    wait_count(4);
    resp_en = 1'b0;
    tick(1);
    chk("t5_head_addr", bus.q_addr, 32'hFFFF_FFFE);
    chk("t5_head_byte", 32'(bus.q_byte), 32'hEF);
    chk("t5_wrap_fetch", bus.mem_address, 32'h0000_0002);
    pulse_snoop(32'hFFFF_FFFD, 1'b0);
    chk("t5_below_miss", 32'(bus.q_count), 32'd4);
    bus.q_take = 1'b1;
    tick(1);
    bus.q_take = 1'b0;
    chk("t5_take_addr", bus.q_addr, 32'hFFFF_FFFF);
    chk("t5_take_byte", 32'(bus.q_byte), 32'h00);
    chk("t5_take_count", 32'(bus.q_count), 32'd3);
    pulse_snoop(32'h0000_0000, 1'b0);
    chk("t5_wrap_hit", 32'(bus.q_count), 32'd0);
    chk("t5_wrap_hit_addr", bus.q_addr, 32'hFFFF_FFFF);

    // locked=0 freezes everything.
    resp_en = 1'b1;
    pulse_flush(32'h0000_0500);
    tick(4);
    hold = int'(bus.q_count);
    bus.locked = 1'b0;
    tick(4);
    chk("lock_freeze", 32'(bus.q_count), 32'(hold));
    bus.locked = 1'b1;
    tick(12);

    // 6: async reset in S_REQ, then a late mem_ready.
    resp_en = 1'b0;
    pulse_flush(32'h0000_2000);
    wait_req(1'b1);
    reset = 1'b1;
    #1;
    chk("t6_async_req", 32'(bus.mem_req), 32'd0);
    chk("t6_async_count", 32'(bus.q_count), 32'd0);
    chk("t6_async_addr", bus.q_addr, 32'd0);
    chk("t6_async_mem_addr", bus.mem_address, 32'd0);
    force_ready = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
    chk("t6_late_ready_count", 32'(bus.q_count), 32'd0);
    chk("t6_late_ready_valid", 32'(bus.q_valid), 32'd0);
    chk("t6_late_ready_req", 32'(bus.mem_req), 32'd0);
    force_ready = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
